// File: rtl/d_cond_pkg.sv
// ============================================================================
// Module  : d_cond_pkg
// Purpose : Shared definitions for the d_input_conditioner slice. Holds the
//           debounce FSM state encoding and the default stability-counter
//           configuration.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package d_cond_pkg;

    // Default stability counter configuration
    localparam int C_DEF_CNT_W         = 4;
    localparam int C_DEF_STABLE_CYCLES = 4;

    // Debounce FSM states. Bit 1 is the committed level and bit 0 marks
    // a qualification in progress.
    typedef enum logic [1:0] {
        IDLE_LOW   = 2'b00,
        CHECK_HIGH = 2'b01,
        IDLE_HIGH  = 2'b10,
        CHECK_LOW  = 2'b11
    } d_cond_state_t;

endpackage : d_cond_pkg

`default_nettype wire

// File: rtl/d_cond_sync.sv
// ============================================================================
// Module  : d_cond_sync
// Purpose : Two-flop synchronizer that brings an asynchronous level into the
//           clk domain. Both flops reset to RESET_LEVEL.
// Ports   : clk   - clock
//           rst   - synchronous active-high reset
//           d_in  - asynchronous input level
//           d_out - synchronized level (two clk of latency)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module d_cond_sync #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic d_out
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_LEVEL;
            r_sync <= RESET_LEVEL;
        end else begin
            r_meta <= d_in;
            r_sync <= r_meta;
        end
    end

    assign d_out = r_sync;

endmodule : d_cond_sync

`default_nettype wire

// File: rtl/d_input_conditioner.sv
// ============================================================================
// Module  : d_input_conditioner
// Purpose : Debounces a raw single-bit level before it feeds the d input of
//           the jdflipflop. A new level is accepted only after it has been
//           sampled STABLE_CYCLES consecutive times on en-qualified edges.
//           Emits registered one-cycle rise/fall pulses on each commit.
// Option  : D_INPUT_CONDITIONER_SYNC_EN - when defined, d_raw passes through
//           a 2-flop synchronizer (d_cond_sync) first; latency grows by 2 clk
//           and d_raw may be asynchronous.
// Ports   : clk     - clock
//           rst     - synchronous active-high reset (highest priority)
//           d_raw   - raw level to condition
//           en      - sample-enable tick; state holds while low
//           d_clean - debounced level
//           rise    - one-cycle pulse on a committed 0->1
//           fall    - one-cycle pulse on a committed 1->0
//           busy    - high while a candidate change is being qualified
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module d_input_conditioner
    import d_cond_pkg::*;
#(
    parameter int   CNT_W         = C_DEF_CNT_W,
    parameter int   STABLE_CYCLES = C_DEF_STABLE_CYCLES,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_raw,
    input  logic en,
    output logic d_clean,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam d_cond_state_t    C_RST_STATE = RESET_LEVEL ? IDLE_HIGH : IDLE_LOW;

    // Reject configurations where the counter cannot reach STABLE_CYCLES-1
    // or where a single sample would be enough to commit.
    if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > ((2 ** CNT_W) - 1))) begin : g_bad_stable_cycles
        $error("d_input_conditioner: STABLE_CYCLES=%0d outside 2..%0d",
               STABLE_CYCLES, (2 ** CNT_W) - 1);
    end

    logic w_sample;

`ifdef D_INPUT_CONDITIONER_SYNC_EN
    d_cond_sync #(
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_raw),
        .d_out (w_sample)
    );
`else
    assign w_sample = d_raw;
`endif

    d_cond_state_t    r_state,   w_state_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic             r_d_clean, w_clean_nxt;
    logic             r_rise,    w_rise_nxt;
    logic             r_fall,    w_fall_nxt;
    logic             r_busy,    w_busy_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= C_RST_STATE;
            r_cnt     <= '0;
            r_d_clean <= RESET_LEVEL;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_d_clean <= w_clean_nxt;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Pulses default low so that an en=0 cycle always terminates them.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clean_nxt = r_d_clean;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;

        if (en) begin
            unique case (r_state)
                IDLE_LOW: begin
                    if (w_sample) begin
                        w_state_nxt = CHECK_HIGH;
                        w_cnt_nxt   = C_CNT_ONE;
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                CHECK_HIGH: begin
                    if (!w_sample) begin
                        w_state_nxt = IDLE_LOW;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        w_state_nxt = IDLE_HIGH;
                        w_cnt_nxt   = '0;
                        w_clean_nxt = 1'b1;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + C_CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!w_sample) begin
                        w_state_nxt = CHECK_LOW;
                        w_cnt_nxt   = C_CNT_ONE;
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                CHECK_LOW: begin
                    if (w_sample) begin
                        w_state_nxt = IDLE_HIGH;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        w_state_nxt = IDLE_LOW;
                        w_cnt_nxt   = '0;
                        w_clean_nxt = 1'b0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + C_CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = C_RST_STATE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // busy is registered alongside the state it describes.
        w_busy_nxt = (w_state_nxt == CHECK_HIGH) || (w_state_nxt == CHECK_LOW);
    end

    assign d_clean = r_d_clean;
    assign rise    = r_rise;
    assign fall    = r_fall;
    assign busy    = r_busy;

endmodule : d_input_conditioner

`default_nettype wire

// File: tb/tb_d_input_conditioner.sv
// ============================================================================
// Module  : tb_d_input_conditioner
// Purpose : Self-checking bench for d_input_conditioner (default build,
//           STABLE_CYCLES=4, RESET_LEVEL=0). Directed vectors carry
//           hand-computed expected outputs {d_clean,rise,fall,busy} that are
//           queued at drive time and checked by an independent monitor after
//           the following clock edge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d_input_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d_raw = 1'b0;
    logic en = 1'b1;
    logic d_clean, rise, fall, busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    d_input_conditioner dut (
        .clk     (clk),
        .rst     (rst),
        .d_raw   (d_raw),
        .en      (en),
        .d_clean (d_clean),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    // Monitor: the DUT presents a registered result every clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if ({d_clean, rise, fall, busy} !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got clean/rise/fall/busy=%b required %b",
                             e.name, {d_clean, rise, fall, busy}, e.exp);
                end
            end
        end
    end

    // Drive one cycle of stimulus and queue the outputs expected after the edge.
    task automatic cyc(input logic r, input logic d, input logic e,
                       input logic [3:0] exp, input string name);
        @(negedge clk);
        rst   = r;
        d_raw = d;
        en    = e;
        q.push_back('{exp: exp, name: name});
    endtask

    initial begin
        // Reset with d_raw high: outputs stay at reset values
        cyc(1, 1, 1, 4'b0000, "reset_c1");
        cyc(1, 1, 1, 4'b0000, "reset_c2");
        // Release: rising qualification starts immediately, commit on edge 4
        cyc(0, 1, 1, 4'b0001, "rise_e1");
        cyc(0, 1, 1, 4'b0001, "rise_e2");
        cyc(0, 1, 1, 4'b0001, "rise_e3");
        cyc(0, 1, 1, 4'b1100, "rise_commit");
        for (int i = 0; i < 6; i++) cyc(0, 1, 1, 4'b1000, "rise_hold");
        // Clean fall
        cyc(0, 0, 1, 4'b1001, "fall_e1");
        cyc(0, 0, 1, 4'b1001, "fall_e2");
        cyc(0, 0, 1, 4'b1001, "fall_e3");
        cyc(0, 0, 1, 4'b0010, "fall_commit");
        cyc(0, 0, 1, 4'b0000, "fall_hold1");
        cyc(0, 0, 1, 4'b0000, "fall_hold2");
        // Glitch of 3 edges, reverting on the would-be commit edge
        cyc(0, 1, 1, 4'b0001, "glitch_e1");
        cyc(0, 1, 1, 4'b0001, "glitch_e2");
        cyc(0, 1, 1, 4'b0001, "glitch_e3");
        cyc(0, 0, 1, 4'b0000, "glitch_revert");
        // Single-cycle pulses never commit
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 4'b0001, "pulse_hi");
            cyc(0, 0, 1, 4'b0000, "pulse_lo");
        end
        // en gating: commit after 4 en-high edges, rise lasts one cycle
        cyc(0, 1, 1, 4'b0001, "en_e1");
        cyc(0, 1, 0, 4'b0001, "en_hold1");
        cyc(0, 1, 1, 4'b0001, "en_e2");
        cyc(0, 1, 0, 4'b0001, "en_hold2");
        cyc(0, 1, 1, 4'b0001, "en_e3");
        cyc(0, 1, 0, 4'b0001, "en_hold3");
        cyc(0, 1, 1, 4'b1100, "en_commit");
        cyc(0, 1, 0, 4'b1000, "en_rise_cleared");
        // en low holds the level even with d_raw low
        cyc(0, 0, 0, 4'b1000, "en_low_hold1");
        cyc(0, 0, 0, 4'b1000, "en_low_hold2");
        // Falling qualification resumes once en returns
        cyc(0, 0, 1, 4'b1001, "enfall_e1");
        cyc(0, 0, 1, 4'b1001, "enfall_e2");
        cyc(0, 0, 1, 4'b1001, "enfall_e3");
        cyc(0, 0, 1, 4'b0010, "enfall_commit");
        // Reset mid-check at cnt=2, then a full run is needed again
        cyc(0, 1, 1, 4'b0001, "midrst_e1");
        cyc(0, 1, 1, 4'b0001, "midrst_e2");
        cyc(1, 1, 1, 4'b0000, "midrst_reset");
        cyc(0, 1, 1, 4'b0001, "midrst_after_e1");
        cyc(0, 1, 1, 4'b0001, "midrst_after_e2");
        cyc(0, 1, 1, 4'b0001, "midrst_after_e3");
        cyc(0, 1, 1, 4'b1100, "midrst_after_commit");
        // Reset while high returns to the reset level with no fall pulse
        cyc(1, 1, 1, 4'b0000, "rst_from_high");
        // Reset coinciding with the commit edge suppresses the pulse
        cyc(0, 1, 1, 4'b0001, "rstcommit_e1");
        cyc(0, 1, 1, 4'b0001, "rstcommit_e2");
        cyc(0, 1, 1, 4'b0001, "rstcommit_e3");
        cyc(1, 1, 1, 4'b0000, "rstcommit_edge");
        cyc(0, 0, 1, 4'b0000, "rstcommit_after");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_d_input_conditioner

`default_nettype wire
